// File: rtl/mouse_cursor_tracker.sv
// Turns PS/2 mouse packets into a clamped absolute cursor position, button press/release ticks and an idle-driven visible flag.
// Optional MOUSE_ACCEL_EN doubles any delta whose magnitude exceeds ACCEL_THRESH.
module mouse_cursor_tracker #(
    parameter int H_MAX        = 639,
    parameter int V_MAX        = 479,
    parameter int X_INIT       = 320,
    parameter int Y_INIT       = 240,
    parameter int IDLE_TIMEOUT = 100_000_000,
    parameter int IDLE_W       = 27,
    parameter int ACCEL_THRESH = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [8:0] xm,
    input  logic [8:0] ym,
    input  logic [2:0] btnm,
    input  logic       m_done_tick,
    input  logic       recenter,
    output logic [9:0] x_pos,
    output logic [9:0] y_pos,
    output logic [2:0] btn_state,
    output logic [2:0] press_tick,
    output logic [2:0] release_tick,
    output logic       pos_tick,
    output logic       cursor_visible
);

    localparam logic signed [11:0] H_LIM    = 12'(H_MAX);
    localparam logic signed [11:0] V_LIM    = 12'(V_MAX);
    localparam logic [9:0]         H_MAX10  = 10'(H_MAX);
    localparam logic [9:0]         V_MAX10  = 10'(V_MAX);
    localparam logic [9:0]         X_INIT10 = 10'(X_INIT);
    localparam logic [9:0]         Y_INIT10 = 10'(Y_INIT);
    localparam logic [IDLE_W-1:0]  IDLE_MAX = IDLE_W'(IDLE_TIMEOUT);

    function automatic logic signed [11:0] scale_delta(input logic [8:0] d);
        logic signed [11:0] s;
        s = {{3{d[8]}}, d};
`ifdef MOUSE_ACCEL_EN
        if (s > 12'(ACCEL_THRESH) || s < -(12'(ACCEL_THRESH)))
            s = s <<< 1;
`endif
        return s;
    endfunction

    logic signed [11:0] dx_s1, dy_s1;
    logic [2:0]         btn_s1;
    logic               valid1;
    logic [IDLE_W-1:0]  idle_cnt;

    logic signed [11:0] nx, ny;
    logic [9:0]         x_next, y_next;
    logic               activity;
    logic [IDLE_W-1:0]  idle_next;

    // 12-bit signed sums leave headroom for a doubled -256/+255 delta from either edge of the screen
    always_comb begin
        nx = $signed({2'b00, x_pos}) + dx_s1;
        ny = $signed({2'b00, y_pos}) - dy_s1;

        if (nx[11])
            x_next = '0;
        else if (nx > H_LIM)
            x_next = H_MAX10;
        else
            x_next = nx[9:0];

        if (ny[11])
            y_next = '0;
        else if (ny > V_LIM)
            y_next = V_MAX10;
        else
            y_next = ny[9:0];

        activity = recenter |
                   (valid1 & ((dx_s1 != '0) | (dy_s1 != '0) | (btn_s1 != btn_state)));

        if (activity)
            idle_next = '0;
        else if (idle_cnt == IDLE_MAX)
            idle_next = idle_cnt;
        else
            idle_next = idle_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dx_s1          <= '0;
            dy_s1          <= '0;
            btn_s1         <= '0;
            valid1         <= 1'b0;
            x_pos          <= X_INIT10;
            y_pos          <= Y_INIT10;
            btn_state      <= '0;
            press_tick     <= '0;
            release_tick   <= '0;
            pos_tick       <= 1'b0;
            idle_cnt       <= '0;
            cursor_visible <= 1'b1;
        end else begin
            valid1 <= m_done_tick;
            if (m_done_tick) begin
                dx_s1  <= scale_delta(xm);
                dy_s1  <= scale_delta(ym);
                btn_s1 <= btnm;
            end

            // recenter wins over a coincident delta but the packet's buttons still land
            if (recenter) begin
                x_pos <= X_INIT10;
                y_pos <= Y_INIT10;
            end else if (valid1) begin
                x_pos <= x_next;
                y_pos <= y_next;
            end

            if (valid1) begin
                btn_state    <= btn_s1;
                press_tick   <= btn_s1 & ~btn_state;
                release_tick <= ~btn_s1 & btn_state;
            end else begin
                press_tick   <= '0;
                release_tick <= '0;
            end

            pos_tick       <= valid1 | recenter;
            idle_cnt       <= idle_next;
            cursor_visible <= (idle_next != IDLE_MAX);
        end
    end

endmodule
